div_multi: RTL
==============

Name: div_multi

Overview:
- Multi-channel, runtime-programmable clock-enable and tick generator.
- Successor to the fixed single-output divider: CH independent channels, per-channel divisor and mode (1-cycle pulse or ~50% square), glitch-free divisor update, and a global phase-sync.
- Feeds sample strobes, UART/LED timing and similar enables in the lms/top-level fabric.
- All outputs are clock enables in the clk domain; no derived clocks are produced.

Parameters:
- CH, 4, number of channels (1..16).
- W, 20, divisor and counter width in bits.
- DEF_DIV, 20, reset divisor of every channel (must be < 2^W).
- CW, $clog2(CH) (min 1), width of the channel-select field; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  CH  per-channel run enable, level.
- sync  in  1  1-cycle strobe that restarts all enabled channels at phase 0.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CW  channel addressed by the write.
- cfg_div  in  W  new divisor N.
- cfg_mode  in  1  0 = pulse, 1 = square.
- cfg_imm  in  1  1 = apply immediately and restart phase; 0 = apply at next terminal count.
- tick  out  CH  1-cycle pulse per period, registered.
- sq  out  CH  square output, registered.
- pend  out  CH  1 = a staged config write is not yet applied.

Behaviour:
- Reset (rst=0, async):
  - cnt=0, div=DEF_DIV, mode=0.
  - tick=0, sq=0, pend=0.
  - Shadow registers cleared.
- Per-channel states: IDLE (en=0 or N=0) and RUN.
- IDLE:
  - cnt held at 0; tick=0, sq=0.
  - Enters RUN on the first edge with en=1 and N>=1.
- RUN, each edge:
  - If cnt==N-1: cnt<=0 and tick<=1. Otherwise cnt<=cnt+1 and tick<=0.
  - With en held from reset and N=20, the first tick is visible after the 20th edge; period is exactly N; duty is 1 cycle.
- en falling: next edge returns the channel to IDLE; cnt, tick and sq are cleared. Re-enable restarts at phase 0.
- Square mode:
  - sq<=1 when next cnt < ceil(N/2), else 0.
  - Result: high for ceil(N/2) cycles, low for floor(N/2) cycles.
  - N=1: sq is constantly 1 while running; tick is constantly 1.
- Pulse mode: sq is held at 0.
- N=0: the channel is forced to IDLE regardless of en (halt encoding).
- Config write, cfg_imm=0:
  - {cfg_div, cfg_mode} go to the channel's shadow register; pend=1.
  - The shadow is applied on the channel's next terminal-count edge (the same edge that pulses tick); pend<=0 on that edge.
  - If the channel is IDLE, the shadow is applied on the next edge.
- Config write, cfg_imm=1:
  - Applied on the next edge; cnt<=0; pend<=0; no tick on that edge.
- A second staged write before apply overwrites the shadow (last write wins).
- A write to cfg_ch >= CH is ignored.
- sync: every RUN channel gets cnt<=0 and tick<=0 on that edge, and staged configs are applied. sync has priority over terminal count and over cfg_imm on the same edge.
- Simultaneous cfg_we and terminal count on the same channel: the old shadow is applied first; the new write stays pending.
- Arithmetic:
  - Compare cnt==N-1 using W-bit unsigned.
  - No overflow is possible, since cnt < N <= 2^W-1.
- Reset mid-period: all channels immediately return to the reset values above.

Optional Feature:
- DIV_TICKCNT_EN defined:
  - Adds input rd_ch[CW] and output tick_cnt[16].
  - Each channel keeps a 16-bit wrap-around tick counter, cleared by reset and by sync.
  - tick_cnt is the registered count of channel rd_ch, with 1-cycle read latency.
- DIV_TICKCNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package div_pkg:
  - mode encoding constants DIV_MODE_PULSE=0 and DIV_MODE_SQUARE=1.
  - state enum {DIV_IDLE, DIV_RUN}.
  - DIV_HALT constant (0).
- Sub-module div_chan: a single channel (counter, shadow, state, tick/sq/pend logic).
- div_multi: decodes cfg_ch, fans out sync, generates CH instances of div_chan, and muxes the optional tick count.

Test Plan:
- Reset, en=4'b0001, default N=20 -> tick[0] first high after the 20th edge, then every 20 cycles; sq=0; other channels silent.
- ch1: cfg_div=5, mode=1, imm=1, then en[1]=1 -> sq[1] pattern 1,1,1,0,0 repeating; tick[1] period 5.
- ch0 running N=20: at cnt=7 write div=8 with imm=0 -> pend[0]=1 until the 20-cycle period completes; tick at cycle 20, then every 8 cycles; pend drops on the tick edge.
- ch0 N=20 and ch2 N=3 running: assert sync -> both counters zeroed; next ticks occur 20 and 3 cycles later; sync on a terminal-count edge suppresses that tick.
- Divisor corners: N=1 -> tick and sq constantly 1; N=0 -> tick=sq=0 even with en=1; drop en mid-period then re-enable -> full N-cycle wait.
- With DIV_TICKCNT_EN: 70 cycles at N=7 -> tick_cnt=10; sync clears it to 0; assert rst=0 mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-channel tick generator.
// Mode encodings, channel state enum and the halt divisor.
package div_pkg;

  localparam logic DIV_MODE_PULSE  = 1'b0;
  localparam logic DIV_MODE_SQUARE = 1'b1;

  // A divisor of zero parks the channel.
  localparam int DIV_HALT = 0;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_e;

endpackage

// File: rtl/div_chan.sv
// One divider channel: counter, config shadow, tick/square/pending flags.
// Ports: en/sync/cfg write in; tick_o, sq_o, pend_o (+tcnt_o with DIV_TICKCNT_EN).
module div_chan
  import div_pkg::*;
#(
  parameter int W       = 20,
  parameter int DEF_DIV = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sync_i,
  input  logic         we_i,
  input  logic [W-1:0] div_i,
  input  logic         mode_i,
  input  logic         imm_i,
  output logic         tick_o,
  output logic         sq_o,
  output logic         pend_o
`ifdef DIV_TICKCNT_EN
  ,
  output logic [15:0]  tcnt_o
`endif
);

  div_state_e   st_q, st_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         mode_q, mode_d;
  logic [W-1:0] sh_div_q, sh_div_d;
  logic         sh_mode_q, sh_mode_d;
  logic         pend_q, pend_d;
  logic         tick_q, tick_d;
  logic         sq_q, sq_d;

  logic         run;
  logic         tc;
  logic         apply_sh;
  logic [W:0]   half;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;

    run = en_i && (div_q != W'(DIV_HALT));
    tc  = run && (cnt_q == div_q - W'(1));

    st_d = run ? DIV_RUN : DIV_IDLE;

    // Staged config lands on sync, terminal count, or any idle edge.
    apply_sh = pend_q && (sync_i || tc || (st_q == DIV_IDLE));
    if (apply_sh) begin
      div_d  = sh_div_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
    end

    // A write racing an apply edge is staged behind the old shadow.
    if (we_i) begin
      if (imm_i && !sync_i) begin
        div_d  = div_i;
        mode_d = mode_i;
        pend_d = 1'b0;
      end else begin
        sh_div_d  = div_i;
        sh_mode_d = mode_i;
        pend_d    = 1'b1;
      end
    end

    if (!run) begin
      cnt_d = '0;
    end else if (sync_i || (we_i && imm_i)) begin
      cnt_d = '0;
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + W'(1);
    end

    half = ({1'b0, div_d} + (W+1)'(1)) >> 1;
    sq_d = run && (mode_d == DIV_MODE_SQUARE)
        && ({1'b0, cnt_d} < half);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= DIV_IDLE;
      cnt_q     <= '0;
      div_q     <= W'(DEF_DIV);
      mode_q    <= DIV_MODE_PULSE;
      sh_div_q  <= '0;
      sh_mode_q <= DIV_MODE_PULSE;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign pend_o = pend_q;

`ifdef DIV_TICKCNT_EN
  logic [15:0] tcnt_q, tcnt_d;

  assign tcnt_d = sync_i ? '0 : tcnt_q + {15'd0, tick_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign tcnt_o = tcnt_q;
`endif

endmodule

// File: rtl/div_multi.sv
// Multi-channel programmable clock-enable / tick generator (top).
// Ports: clk, rst(n), en, sync, cfg_*; tick, sq, pend. DIV_TICKCNT_EN adds rd_ch/tick_cnt.
module div_multi
  import div_pkg::*;
#(
  parameter int CH      = 4,
  parameter int W       = 20,
  parameter int DEF_DIV = 20,
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_div,
  input  logic          cfg_mode,
  input  logic          cfg_imm,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] sq,
  output logic [CH-1:0] pend
`ifdef DIV_TICKCNT_EN
  ,
  input  logic [CW-1:0] rd_ch,
  output logic [15:0]   tick_cnt
`endif
);

`ifdef DIV_TICKCNT_EN
  logic [15:0] tcnt [CH];
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic we;

    // Out-of-range channel numbers match no instance.
    assign we = cfg_we && (int'(cfg_ch) == i);

    div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en[i]),
      .sync_i (sync),
      .we_i   (we),
      .div_i  (cfg_div),
      .mode_i (cfg_mode),
      .imm_i  (cfg_imm),
      .tick_o (tick[i]),
      .sq_o   (sq[i]),
      .pend_o (pend[i])
`ifdef DIV_TICKCNT_EN
      ,
      .tcnt_o (tcnt[i])
`endif
    );
  end

`ifdef DIV_TICKCNT_EN
  logic [15:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(rd_ch) == i) begin
        tick_cnt_d = tcnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule
